score_sseg_scan: RTL
====================

Name: score_sseg_scan

Overview:
- Downstream consumer of the scoreboard's combinational binary-to-BCD converter.
- Takes the packed BCD score vector and time-multiplexes it onto the board's common-anode seven-segment display.
- Scans one digit per refresh tick.
- Captures new scores tear-free, only at frame boundaries.
- Optionally suppresses leading zeros.

Parameters:
- BCD_W, 18, width of packed BCD input (a 14-bit binary score gives 18 BCD bits).
- DIGITS, 5, number of digits scanned, 1..8; digit i = bcd bits [4i+3:4i], missing upper bits zero-filled.
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz slot at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- bcd_in  input  BCD_W  packed BCD score {…,thousands,hundreds,tens,ones}.
- bcd_valid  input  1  single-cycle strobe: bcd_in holds a new score.
- an  output  8  anode enables, active-low; an[i] = digit i; bits ≥ DIGITS always 1.
- seg  output  7  cathodes, active-low, order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low; always 1 (off).
- frame_done  output  1  one-cycle pulse when the slot of digit DIGITS-1 ends.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - an = 8'hFF, seg = 7'h7F, dp = 1, frame_done = 0.
  - Refresh counter = 0, digit index = 0.
  - Pending and display registers = 0, pending_flag = 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted when the count equals REFRESH_DIV-1.
- Digit index:
  - Advances on tick; wraps DIGITS-1 -> 0.
  - frame_done pulses (registered) on the tick where the index wraps.
- Score capture:
  - On bcd_valid, bcd_in is latched into the pending register and pending_flag is set.
  - On a wrap tick with pending_flag set, pending is copied to the display register and pending_flag is cleared.
  - Repeated bcd_valid within one frame: the last value wins.
- Simultaneous bcd_valid and wrap tick: bcd_in is loaded directly into the display register, bypassing pending. pending_flag ends 0.
- Output stage:
  - an and seg are registered from the display register and the current digit index.
  - They change exactly 1 cycle after the index changes, and after reset release the first digit is driven 1 cycle after reset deasserts.
  - Only one an bit is low at any time.
- Segment decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble >9 -> 0111111 (dash, error indicator).
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous); the scan restarts at digit 0.
- bcd_in is sampled only when bcd_valid = 1; it is don't-care otherwise.

Optional Feature:
- Macro: SSEG_LEADING_ZERO_BLANK_EN.
- With the macro defined:
  - A digit is blanked (seg = 7'h7F, its an bit still low) if it and every more-significant digit are zero.
  - Digit 0 is never blanked, so a score of 0 shows "0".
  - Blanking is computed from the display register, so it is also frame-consistent.
- Without the macro: all DIGITS digits are shown, including leading zeros.

Test Plan:
- Reset behaviour, REFRESH_DIV=4, DIGITS=5: assert rst asynchronously mid-cycle -> an=FF, seg=7F immediately. After release: an=FE (digit 0) within 1 cycle, and an steps FE,FD,FB,F7,EF every 4 cycles; frame_done pulses once per 20 cycles.
- Score display: bcd_valid with bcd_in=18'h01234 (score 1234) during a frame -> display unchanged until wrap. Next frame seg sequence for digits 0..4 is 0011001, 0110000, 0100100, 1111001, 1000000 (or blank for digit 4 when SSEG_LEADING_ZERO_BLANK_EN is defined).
- Last-wins and coincidence: two bcd_valid in one frame (0x00005 then 0x00009) -> next frame shows 9. bcd_valid of 0x00007 on the exact wrap tick -> that frame shows 7, and a later wrap does not overwrite it.
- Error and maximum values: bcd_in nibble 0 = 4'hA -> digit 0 shows 0111111. bcd_in=18'h16383 -> digits show 3,8,3,6,1.
- Blanking, macro defined: score 0 -> only digit 0 lit as 1000000, digits 1..4 seg=7F. Score 0x10005 -> no digit blanked, zeros in the middle shown as 1000000.

Source files
------------

// File: rtl/score_sseg_scan.sv
// Frame-synchronous seven-segment scanner for a packed BCD score (common-anode, active-low).
// Optional leading-zero blanking is enabled by defining SSEG_LEADING_ZERO_BLANK_EN.
module score_sseg_scan #(
   parameter int unsigned BCD_W       = 18,
   parameter int unsigned DIGITS      = 5,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BCD_W-1:0] bcd_in,
   input  logic             bcd_valid,
   output logic [7:0]       an,
   output logic [6:0]       seg,
   output logic             dp,
   output logic             frame_done
);

   localparam int unsigned DISP_W = 4 * DIGITS;
   localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W  = 3;

   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [DISP_W-1:0] pending;
   logic [DISP_W-1:0] display;
   logic              pending_flag;

   logic              tick_c;
   logic              wrap_c;
   logic [DISP_W-1:0] bcd_ext_c;
   logic [3:0]        digit_c;
   logic              blank_c;
   logic [6:0]        seg_c;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b0111111;
      endcase
   endfunction

   assign tick_c    = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign wrap_c    = tick_c && (idx == IDX_W'(DIGITS - 1));
   assign bcd_ext_c = DISP_W'(bcd_in);

   // Nibble of the display register selected by the current scan index.
   always_comb begin
      digit_c = 4'd0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (idx == IDX_W'(i)) digit_c = display[4*i +: 4];
      end
   end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
   // A digit blanks when it and everything above it are zero; digit 0 always shows.
   always_comb begin : blank_scan
      logic zero_run;
      zero_run = 1'b1;
      blank_c  = 1'b0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         zero_run = zero_run && (display[4*i +: 4] == 4'd0);
         if (idx == IDX_W'(i)) blank_c = zero_run;
      end
   end
`else
   assign blank_c = 1'b0;
`endif

   assign seg_c = blank_c ? 7'h7F : seg_decode(digit_c);

   // Refresh divider and digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= tick_c ? '0 : cnt + CNT_W'(1);
         if (tick_c) idx <= wrap_c ? '0 : idx + IDX_W'(1);
      end
   end

   // Score capture: new values wait in pending until the frame boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending      <= '0;
         display      <= '0;
         pending_flag <= 1'b0;
      end else if (wrap_c && bcd_valid) begin
         display      <= bcd_ext_c;
         pending_flag <= 1'b0;
      end else if (wrap_c) begin
         if (pending_flag) display <= pending;
         pending_flag <= 1'b0;
      end else if (bcd_valid) begin
         pending      <= bcd_ext_c;
         pending_flag <= 1'b1;
      end
   end

   // Registered display drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= 8'hFF;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         an         <= ~(8'h01 << idx);
         seg        <= seg_c;
         dp         <= 1'b1;
         frame_done <= wrap_c;
      end
   end

endmodule
